// File: rtl/frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_pkg                                                                  |
// | Shared frame geometry, FSM encoding and sentinel values for the checker.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package frame_pkg;

   localparam int FRAME_BYTES = 16;
   localparam int BYTE_CNT_W  = $clog2(FRAME_BYTES);

   // Sentinel for the first-error register: the frame holds zero bit errors
   localparam logic [7:0] NO_ERROR_POS = 8'hFF;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECEIVE = 2'd1,
      REPORT  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_error_compare.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | byte_error_compare                                                         |
// | XOR compare of one received byte against its golden byte.                  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module byte_error_compare (
   input  logic [7:0] rx_byte,
   input  logic [7:0] exp_byte,
   output logic       diff_nonzero,
   output logic [3:0] popcount,
   output logic [2:0] first_bit
);

   logic [7:0] w_diff;

   assign w_diff       = rx_byte ^ exp_byte;
   assign diff_nonzero = |w_diff;

   always_comb begin
      popcount = 4'd0;
      for (int i = 0; i < 8; i++) begin
         popcount = popcount + {3'd0, w_diff[i]};
      end
   end

   // Scan from the top so the lowest set bit is the last one written
   always_comb begin
      first_bit = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_diff[i]) begin
            first_bit = 3'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/frame_checker_with_error_detection.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_checker_with_error_detection                                         |
// | Assembles frames from a byte stream, counts bit errors against a golden    |
// | frame, locates the first error and keeps saturating frame statistics.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module frame_checker_with_error_detection #(
   parameter int FRAME_BYTES    = frame_pkg::FRAME_BYTES,
   parameter int TIMEOUT_CYCLES = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [7:0]               frame_data,
   input  logic                     valid,
   input  logic [8*FRAME_BYTES-1:0] expected_frame,
   output logic                     frame_done,
   output logic                     frame_ok,
   output logic                     frame_abort,
   output logic [7:0]               error_count,
   output logic [7:0]               first_error_position,
   output logic [CNT_WIDTH-1:0]     frames_total,
   output logic [CNT_WIDTH-1:0]     frames_bad
);

   import frame_pkg::*;

   localparam int c_BCW = (FRAME_BYTES == frame_pkg::FRAME_BYTES) ? BYTE_CNT_W :
                          (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
   localparam int c_IW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_BCW-1:0] c_LAST_IDX   = c_BCW'(FRAME_BYTES - 1);
   localparam logic [c_IW-1:0]  c_IDLE_LIMIT = c_IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit               c_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [c_BCW-1:0]       r_byte_cnt;
   logic [c_IW-1:0]        r_idle_cnt;
   logic [7:0]             r_acc;
   logic [7:0]             r_first_pos;
   logic                   r_frame_ok;
   logic                   r_frame_abort;
   logic [7:0]             r_error_count;
   logic [7:0]             r_first_error_position;
   logic [CNT_WIDTH-1:0]   r_frames_total;
   logic [CNT_WIDTH-1:0]   r_frames_bad;

   logic [7:0]             w_exp_bytes [FRAME_BYTES];
   logic [c_BCW-1:0]       w_idx;
   logic [7:0]             w_exp_byte;
   logic                   w_start;
   logic                   w_last;
   logic                   w_timeout;
   logic                   w_diff_nonzero;
   logic [3:0]             w_popcount;
   logic [2:0]             w_first_bit;
   logic [7:0]             w_acc_base;
   logic [7:0]             w_acc_new;
   logic [7:0]             w_first_base;
   logic [7:0]             w_first_new;

   generate
      for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_exp_bytes
         assign w_exp_bytes[gi] = expected_frame[8*gi +: 8];
      end
   endgenerate

   // Outside RECEIVE a valid byte is always byte 0 of a new frame
   assign w_idx      = (r_state == RECEIVE) ? r_byte_cnt : '0;
   assign w_exp_byte = w_exp_bytes[w_idx];
   assign w_start    = valid && (r_state != RECEIVE);
   assign w_last     = valid && (w_idx == c_LAST_IDX);
   assign w_timeout  = c_TIMEOUT_EN && (r_state == RECEIVE) && !valid &&
                       (r_idle_cnt == c_IDLE_LIMIT);

   byte_error_compare u_byte_cmp (
      .rx_byte      (frame_data),
      .exp_byte     (w_exp_byte),
      .diff_nonzero (w_diff_nonzero),
      .popcount     (w_popcount),
      .first_bit    (w_first_bit)
   );

   assign w_acc_base   = w_start ? 8'd0 : r_acc;
   assign w_acc_new    = w_acc_base + {4'd0, w_popcount};
   assign w_first_base = w_start ? NO_ERROR_POS : r_first_pos;
   assign w_first_new  = ((w_first_base == NO_ERROR_POS) && w_diff_nonzero) ?
                         8'({w_idx, w_first_bit}) : w_first_base;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      frame_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (valid) begin
               w_state_nxt = w_last ? REPORT : RECEIVE;
            end
         end
         RECEIVE: begin
            if (w_last) begin
               w_state_nxt = REPORT;
            end else if (w_timeout) begin
               w_state_nxt = IDLE;
            end
         end
         REPORT: begin
            frame_done = 1'b1;
            if (valid) begin
               w_state_nxt = w_last ? REPORT : RECEIVE;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_byte_cnt  <= '0;
         r_idle_cnt  <= '0;
         r_acc       <= 8'd0;
         r_first_pos <= NO_ERROR_POS;
      end else if (valid) begin
         r_byte_cnt  <= w_last ? '0 : w_idx + c_BCW'(1);
         r_idle_cnt  <= '0;
         r_acc       <= w_acc_new;
         r_first_pos <= w_first_new;
      end else if (r_state == RECEIVE) begin
         if (w_timeout) begin
            r_byte_cnt <= '0;
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + c_IW'(1);
         end
      end
   end

   // Results land on the edge that samples the last byte so they are valid with frame_done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_frame_ok             <= 1'b0;
         r_frame_abort          <= 1'b0;
         r_error_count          <= 8'd0;
         r_first_error_position <= NO_ERROR_POS;
         r_frames_total         <= '0;
         r_frames_bad           <= '0;
      end else begin
         r_frame_abort <= w_timeout;
         if (w_last) begin
            r_error_count          <= w_acc_new;
            r_first_error_position <= w_first_new;
            r_frame_ok             <= (w_acc_new == 8'd0);
            if (r_frames_total != '1) begin
               r_frames_total <= r_frames_total + CNT_WIDTH'(1);
            end
            if ((w_acc_new != 8'd0) && (r_frames_bad != '1)) begin
               r_frames_bad <= r_frames_bad + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign frame_ok             = r_frame_ok;
   assign frame_abort          = r_frame_abort;
   assign error_count          = r_error_count;
   assign first_error_position = r_first_error_position;
   assign frames_total         = r_frames_total;
   assign frames_bad           = r_frames_bad;

endmodule
`default_nettype wire

// File: tb/tb_frame_checker_with_error_detection.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_frame_checker_with_error_detection                                      |
// | Self-checking bench: directed and randomized frames against a bit model.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_frame_checker_with_error_detection;

   localparam int NB = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic [7:0]   frame_data;
   logic         valid;
   logic [127:0] expected_frame;
   logic         frame_done;
   logic         frame_ok;
   logic         frame_abort;
   logic [7:0]   error_count;
   logic [7:0]   first_error_position;
   logic [15:0]  frames_total;
   logic [15:0]  frames_bad;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_b [NB];
   logic [7:0] tx_b  [NB];

   int m_cnt   = 0;
   int m_first = 255;
   bit m_ok    = 1'b0;
   int m_total = 0;
   int m_bad   = 0;

   always #5 clk = ~clk;

   frame_checker_with_error_detection #(
      .FRAME_BYTES    (16),
      .TIMEOUT_CYCLES (32),
      .CNT_WIDTH      (16)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .frame_data           (frame_data),
      .valid                (valid),
      .expected_frame       (expected_frame),
      .frame_done           (frame_done),
      .frame_ok             (frame_ok),
      .frame_abort          (frame_abort),
      .error_count          (error_count),
      .first_error_position (first_error_position),
      .frames_total         (frames_total),
      .frames_bad           (frames_bad)
   );

   // Reference: count every differing bit; first error is the lowest global bit index
   function automatic void model_frame();
      int cnt = 0;
      int first = 255;
      for (int i = 0; i < NB; i++) begin
         for (int b = 0; b < 8; b++) begin
            if (tx_b[i][b] != exp_b[i][b]) begin
               cnt++;
               if (first == 255) first = i * 8 + b;
            end
         end
      end
      m_cnt   = cnt;
      m_first = first;
      m_ok    = (cnt == 0);
      if (m_total < 65535) m_total++;
      if (cnt > 0 && m_bad < 65535) m_bad++;
   endfunction

   function automatic void model_reset();
      m_cnt = 0; m_first = 255; m_ok = 1'b0; m_total = 0; m_bad = 0;
   endfunction

   task automatic load_expected();
      for (int i = 0; i < NB; i++) expected_frame[8*i +: 8] = exp_b[i];
   endtask

   task automatic set_clean_pattern();
      logic [7:0] head [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      for (int i = 0; i < NB; i++) begin
         exp_b[i] = (i < 6) ? head[i] : 8'(i - 5);
         tx_b[i]  = exp_b[i];
      end
   endtask

   // Drives tx_b; returns right after the last byte has been put on the bus
   task automatic send_frame(input int gap_max, input bit no_wait_first);
      for (int i = 0; i < NB; i++) begin
         if (!(i == 0 && no_wait_first)) @(negedge clk);
         if (i == 0) load_expected();
         frame_data = tx_b[i];
         valid      = 1'b1;
         if (i < NB - 1 && gap_max > 0) begin
            int g;
            g = $urandom_range(gap_max, 0);
            repeat (g) begin
               @(negedge clk);
               valid      = 1'b0;
               frame_data = 8'($urandom);
            end
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b1; valid = 1'b0; frame_data = 8'h00; expected_frame = '0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({frame_done, frame_abort, frame_ok, error_count, first_error_position, frames_total, frames_bad}
          !== {1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 16'h0000, 16'h0000}) begin
         tests_failed++;
         $display("FAIL reset_values: done=%b abort=%b ok=%b cnt=%0d pos=%h tot=%0d bad=%0d expected 0 0 0 0 ff 0 0",
                  frame_done, frame_abort, frame_ok, error_count, first_error_position, frames_total, frames_bad);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_clean();
      set_clean_pattern();
      send_frame(0, 1'b0);
      tests_run++;
      if (frame_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL clean_early_done: frame_done=%b expected 0 while last byte on bus", frame_done);
      end
      @(negedge clk);
      valid = 1'b0;
      model_frame();
      tests_run++;
      if (frame_done !== 1'b1) begin
         tests_failed++;
         $display("FAIL clean_done: frame_done=%b expected 1", frame_done);
      end
      tests_run++;
      if ({frame_ok, error_count, first_error_position, frames_total, frames_bad}
          !== {m_ok, 8'(m_cnt), 8'(m_first), 16'(m_total), 16'(m_bad)}) begin
         tests_failed++;
         $display("FAIL clean_result: ok=%b cnt=%0d pos=%h tot=%0d bad=%0d expected %b %0d %h %0d %0d",
                  frame_ok, error_count, first_error_position, frames_total, frames_bad,
                  m_ok, m_cnt, m_first, m_total, m_bad);
      end
      @(negedge clk);
      tests_run++;
      if (frame_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL clean_done_width: frame_done=%b expected 0 one cycle after report", frame_done);
      end
   endtask

   task automatic run_and_check(input string name, input int gap_max);
      send_frame(gap_max, 1'b0);
      @(negedge clk);
      valid = 1'b0;
      model_frame();
      tests_run++;
      if (frame_done !== 1'b1 ||
          {frame_ok, error_count, first_error_position, frames_total, frames_bad}
          !== {m_ok, 8'(m_cnt), 8'(m_first), 16'(m_total), 16'(m_bad)}) begin
         tests_failed++;
         $display("FAIL %s: done=%b ok=%b cnt=%0d pos=%h tot=%0d bad=%0d expected 1 %b %0d %h %0d %0d",
                  name, frame_done, frame_ok, error_count, first_error_position, frames_total, frames_bad,
                  m_ok, m_cnt, m_first, m_total, m_bad);
      end
   endtask

   task automatic test_single_error();
      set_clean_pattern();
      tx_b[0] = 8'hBA;
      run_and_check("single_error", 0);
   endtask

   task automatic test_multi_error();
      set_clean_pattern();
      tx_b[2] = 8'hCD;
      tx_b[9] = 8'hFB;
      run_and_check("multi_error", 0);
   endtask

   task automatic test_all_bits_wrong();
      for (int i = 0; i < NB; i++) begin
         exp_b[i] = 8'($urandom);
         tx_b[i]  = ~exp_b[i];
      end
      run_and_check("all_bits_wrong", 0);
   endtask

   task automatic test_timeout();
      int abort_seen = 0;
      int abort_at   = -1;
      bit done_seen  = 1'b0;
      set_clean_pattern();
      load_expected();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         frame_data = tx_b[i];
         valid      = 1'b1;
      end
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         valid = 1'b0;
         if (k > 1 && frame_abort === 1'b1) begin
            abort_seen++;
            if (abort_at < 0) abort_at = k - 1;
         end
         if (frame_done === 1'b1) done_seen = 1'b1;
      end
      tests_run++;
      if (abort_seen != 1 || abort_at != 32) begin
         tests_failed++;
         $display("FAIL timeout_abort: pulses=%0d at_low_cycle=%0d expected 1 pulse at 32", abort_seen, abort_at);
      end
      tests_run++;
      if (done_seen || {frame_ok, error_count, first_error_position, frames_total, frames_bad}
          !== {m_ok, 8'(m_cnt), 8'(m_first), 16'(m_total), 16'(m_bad)}) begin
         tests_failed++;
         $display("FAIL timeout_unchanged: done_seen=%b ok=%b cnt=%0d pos=%h tot=%0d bad=%0d expected 0 %b %0d %h %0d %0d",
                  done_seen, frame_ok, error_count, first_error_position, frames_total, frames_bad,
                  m_ok, m_cnt, m_first, m_total, m_bad);
      end
      run_and_check("after_timeout", 0);
   endtask

   task automatic test_random_gaps();
      for (int f = 0; f < 24; f++) begin
         for (int i = 0; i < NB; i++) begin
            exp_b[i] = 8'($urandom);
            tx_b[i]  = exp_b[i];
            if ((f % 4) != 0 && $urandom_range(3, 0) == 0) tx_b[i] = exp_b[i] ^ 8'($urandom);
         end
         run_and_check("random_gaps", 3);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      set_clean_pattern();
      tx_b[5] = 8'h7F;
      send_frame(0, 1'b0);
      @(negedge clk);
      model_frame();
      tests_run++;
      if (frame_done !== 1'b1 || {frame_ok, error_count, first_error_position, frames_total, frames_bad}
          !== {m_ok, 8'(m_cnt), 8'(m_first), 16'(m_total), 16'(m_bad)}) begin
         tests_failed++;
         $display("FAIL b2b_first: done=%b ok=%b cnt=%0d pos=%h tot=%0d bad=%0d expected 1 %b %0d %h %0d %0d",
                  frame_done, frame_ok, error_count, first_error_position, frames_total, frames_bad,
                  m_ok, m_cnt, m_first, m_total, m_bad);
      end
      set_clean_pattern();
      send_frame(0, 1'b1);
      @(negedge clk);
      valid = 1'b0;
      model_frame();
      tests_run++;
      if (frame_done !== 1'b1 || {frame_ok, error_count, first_error_position, frames_total, frames_bad}
          !== {m_ok, 8'(m_cnt), 8'(m_first), 16'(m_total), 16'(m_bad)}) begin
         tests_failed++;
         $display("FAIL b2b_second: done=%b ok=%b cnt=%0d pos=%h tot=%0d bad=%0d expected 1 %b %0d %h %0d %0d",
                  frame_done, frame_ok, error_count, first_error_position, frames_total, frames_bad,
                  m_ok, m_cnt, m_first, m_total, m_bad);
      end
   endtask

   task automatic test_reset_mid_frame();
      set_clean_pattern();
      load_expected();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         frame_data = tx_b[i];
         valid      = 1'b1;
      end
      @(negedge clk);
      valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      tests_run++;
      if ({frame_done, frame_abort, frame_ok, error_count, first_error_position, frames_total, frames_bad}
          !== {1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 16'h0000, 16'h0000}) begin
         tests_failed++;
         $display("FAIL reset_mid_values: done=%b abort=%b ok=%b cnt=%0d pos=%h tot=%0d bad=%0d expected 0 0 0 0 ff 0 0",
                  frame_done, frame_abort, frame_ok, error_count, first_error_position, frames_total, frames_bad);
      end
      @(negedge clk);
      reset = 1'b0;
      run_and_check("after_mid_reset", 0);
   endtask

   initial begin
      test_reset();
      test_clean();
      test_single_error();
      test_multi_error();
      test_all_bits_wrong();
      test_timeout();
      test_random_gaps();
      test_back_to_back();
      test_reset_mid_frame();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
